// File: rtl/nfc_command_get_feature.sv
// NAND GET FEATURES sequencer: issues the EEh command and the feature address
// through the CA primitive, waits out the device busy period on the selected
// way, then collects the four parameter bytes P1..P4 via the data-in primitive.
module nfc_command_get_feature #(
   parameter int         NumberOfWays = 4,
   parameter logic [5:0] CommandID    = 6'b000011,
   parameter int         RBLowTimeout = 32
) (
   input  logic                    iSystemClock,
   input  logic                    iReset,
   input  logic [5:0]              iOpcode,
   input  logic                    iCMDValid,
   output logic                    oCMDReady,
   input  logic [NumberOfWays-1:0] iWaySelect,
   input  logic [7:0]              iFeatureAddress,
   output logic                    oStart,
   output logic                    oLastStep,
   output logic [31:0]             oFeatureData,
   output logic                    oFeatureValid,
   output logic [7:0]              oACG_Command,
   output logic [2:0]              oACG_CommandOption,
   input  logic [7:0]              iACG_Ready,
   input  logic [7:0]              iACG_LastStep,
   output logic [NumberOfWays-1:0] oACG_TargetWay,
   output logic [15:0]             oACG_NumOfData,
   output logic                    oACG_CASelect,
   output logic [39:0]             oACG_CAData,
   input  logic [15:0]             iACG_ReadData,
   input  logic                    iACG_ReadLast,
   input  logic                    iACG_ReadValid,
   output logic                    oACG_ReadReady,
   input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

   typedef enum logic [3:0] {
      ST_RESET, ST_READY, ST_CMD_LATCH, ST_CMD_ISSUE, ST_ADDR_ISSUE,
      ST_WAIT_RB_LOW, ST_WAIT_RB_HIGH, ST_DATA_READ, ST_DONE
   } state_t;

   localparam logic [5:0] TimeoutLast = 6'(RBLowTimeout - 1);

   state_t                  state_q, state_d;
   logic                    cmd_ready_q, last_step_q, read_ready_q, ca_select_q;
   logic [7:0]              command_q;
   logic [15:0]             num_of_data_q;
   logic [39:0]             ca_data_q;
   logic [NumberOfWays-1:0] way_q;
   logic [7:0]              addr_q;
   logic [NumberOfWays-1:0] rb_stage1_q;
   logic                    rb_stage2_q;
   logic [5:0]              timeout_q;
   logic                    word_sel_q;
   logic [31:0]             data_q;
   logic                    data_valid_q;
   logic                    ca_done, accept;
   logic                    acg_inputs_unused;

   // The primitive handshake is driven purely by requests and LastStep[6];
   // the ready flags and the other done bits are intentionally ignored.
   assign acg_inputs_unused = ^{iACG_Ready, iACG_LastStep[7], iACG_LastStep[5:0]};

   assign oStart             = (iOpcode == CommandID) & iCMDValid;
   assign ca_done            = iACG_LastStep[6];
   assign accept             = iACG_ReadValid & read_ready_q;

   assign oCMDReady          = cmd_ready_q;
   assign oLastStep          = last_step_q;
   assign oFeatureData       = data_q;
   assign oFeatureValid      = data_valid_q;
   assign oACG_Command       = command_q;
   assign oACG_CommandOption = '0;
   assign oACG_TargetWay     = way_q;
   assign oACG_NumOfData     = num_of_data_q;
   assign oACG_CASelect      = ca_select_q;
   assign oACG_CAData        = ca_data_q;
   assign oACG_ReadReady     = read_ready_q;

   // Next-state selection; reset forces the RESET state.
   always_comb begin
      state_d = state_q;
      if (iReset) begin
         state_d = ST_RESET;
      end else begin
         case (state_q)
            ST_RESET:        state_d = ST_READY;
            ST_READY:        if (oStart) state_d = ST_CMD_LATCH;
            ST_CMD_LATCH:    state_d = ST_CMD_ISSUE;
            ST_CMD_ISSUE:    if (ca_done) state_d = ST_ADDR_ISSUE;
            ST_ADDR_ISSUE:   if (ca_done) state_d = ST_WAIT_RB_LOW;
            ST_WAIT_RB_LOW:  if (!rb_stage2_q || (timeout_q == TimeoutLast)) state_d = ST_WAIT_RB_HIGH;
            ST_WAIT_RB_HIGH: if (rb_stage2_q) state_d = ST_DATA_READ;
            ST_DATA_READ:    if (accept && (word_sel_q || iACG_ReadLast)) state_d = ST_DONE;
            ST_DONE:         state_d = ST_READY;
            default:         state_d = ST_READY;
         endcase
      end
   end

   // State register with primitive-request outputs decoded from the next state.
   always_ff @(posedge iSystemClock) begin
      state_q       <= state_d;
      cmd_ready_q   <= (state_d == ST_RESET) || (state_d == ST_READY);
      last_step_q   <= (state_d == ST_DONE);
      read_ready_q  <= (state_d == ST_DATA_READ);
      command_q     <= 8'h00;
      num_of_data_q <= 16'd0;
      ca_select_q   <= 1'b1;
      ca_data_q     <= '0;
      case (state_d)
         ST_CMD_ISSUE: begin
            command_q     <= 8'h40;
            num_of_data_q <= 16'd1;
            ca_data_q     <= {8'hEE, 32'h0};
         end
         ST_ADDR_ISSUE: begin
            command_q     <= 8'h40;
            num_of_data_q <= 16'd1;
            ca_select_q   <= 1'b0;
            ca_data_q     <= {addr_q, 32'h0};
         end
         ST_DATA_READ: begin
            command_q     <= 8'h10;
            num_of_data_q <= 16'd4;
            ca_select_q   <= 1'b0;
         end
         default: ;
      endcase
   end

   // Capture target way and feature address on the edge that accepts the command.
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         way_q  <= '0;
         addr_q <= '0;
      end else if (state_d == ST_CMD_LATCH) begin
         way_q  <= iWaySelect;
         addr_q <= iFeatureAddress;
      end
   end

   // Two-stage R/B synchronizer on the selected way plus the R/B-low timeout.
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         rb_stage1_q <= '0;
         rb_stage2_q <= 1'b0;
         timeout_q   <= '0;
      end else begin
         rb_stage1_q <= way_q & iACG_ReadyBusy;
         rb_stage2_q <= |rb_stage1_q;
         timeout_q   <= (state_q == ST_WAIT_RB_LOW) ? timeout_q + 6'd1 : '0;
      end
   end

   // Assemble the two data-in words into P1..P4 and track result validity.
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         word_sel_q   <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
      end else begin
         if (state_q == ST_CMD_LATCH) begin
            word_sel_q <= 1'b0;
         end else if (accept) begin
            word_sel_q <= 1'b1;
         end
         if (accept) begin
            if (!word_sel_q) begin
               data_q[31:16] <= iACG_ReadData;
               if (iACG_ReadLast) data_q[15:0] <= 16'h0000;
            end else begin
               data_q[15:0] <= iACG_ReadData;
            end
         end
         if (state_d == ST_CMD_LATCH) begin
            data_valid_q <= 1'b0;
         end else if (state_d == ST_DONE) begin
            data_valid_q <= 1'b1;
         end
      end
   end

endmodule
